// File: rtl/mem_responder_if.sv
// Processor memory request/response bundle between control unit (master) and memory responder (slave).
interface mem_responder_if;
  logic        memory_read_req;
  logic        memory_write_req;
  logic [25:0] memory_addr;
  logic [31:0] memory_data_write;
  logic [31:0] memory_data_read;
  logic        memory_busy;

  modport master (
    output memory_read_req, memory_write_req, memory_addr, memory_data_write,
    input  memory_data_read, memory_busy
  );

  modport slave (
    input  memory_read_req, memory_write_req, memory_addr, memory_data_write,
    output memory_data_read, memory_busy
  );
endinterface

// File: rtl/mem_responder.sv
// Block-RAM memory responder: busy for WAIT_STATES+2 cycles per access, requests ignored while busy.
// Optional LED register at LED_ADDR when MEM_RESPONDER_LED_MMIO_EN is defined.
module mem_responder #(
  parameter int          DEPTH_LOG2  = 10,
  parameter int          WAIT_STATES = 1,
  parameter logic [25:0] LED_ADDR    = 26'h3FFFFFF
) (
  input  logic           clk,
  input  logic           reset,
  mem_responder_if.slave mem,
  output logic [1:0]     led_reg,
  output logic           bad_access
);
  localparam int          WORDS     = 2 ** DEPTH_LOG2;
  localparam logic [26:0] RAM_LIMIT = 27'(WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;
  logic [25:0] addr_q;
  logic [31:0] wdata_q;
  logic        wr_q;
  logic [31:0] data_read_q;
  logic        busy_q;
  logic [31:0] ram [WORDS];

  logic accept;
  logic finish;
  logic at_led;
  logic hit_led;
  logic hit_ram;

  assign accept = (state == IDLE) && (mem.memory_read_req || mem.memory_write_req);
  assign finish = (state == ACCESS);
  assign at_led = (addr_q == LED_ADDR);

`ifdef MEM_RESPONDER_LED_MMIO_EN
  assign hit_led = at_led;
`else
  assign hit_led = 1'b0;
`endif
  // LED_ADDR never falls through to RAM, even without the LED register.
  assign hit_ram = !at_led && ({1'b0, addr_q} < RAM_LIMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = WAIT;
      WAIT:    if (cnt == 4'd0) state_nxt = ACCESS;
      ACCESS:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= 4'd0;
      addr_q      <= 26'd0;
      wdata_q     <= 32'd0;
      wr_q        <= 1'b0;
      data_read_q <= 32'd0;
      busy_q      <= 1'b0;
      bad_access  <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= mem.memory_addr;
        wdata_q <= mem.memory_data_write;
        wr_q    <= mem.memory_write_req;
        cnt     <= 4'(WAIT_STATES);
        busy_q  <= 1'b1;
        // Simultaneous read+write: the write wins and the collision is flagged.
        if (mem.memory_read_req && mem.memory_write_req) bad_access <= 1'b1;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end

      if (finish) begin
        busy_q <= 1'b0;
        if (!wr_q) begin
          if (hit_led)      data_read_q <= {30'd0, led_reg};
          else if (hit_ram) data_read_q <= ram[addr_q[DEPTH_LOG2-1:0]];
          else              data_read_q <= 32'hDEADBEEF;
        end
        if (!hit_led && !hit_ram) bad_access <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (finish && wr_q && hit_ram) ram[addr_q[DEPTH_LOG2-1:0]] <= wdata_q;
  end

`ifdef MEM_RESPONDER_LED_MMIO_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          led_reg <= 2'b00;
    else if (finish && wr_q && hit_led) led_reg <= wdata_q[1:0];
  end
`else
  assign led_reg = 2'b00;
`endif

  assign mem.memory_data_read = data_read_q;
  assign mem.memory_busy      = busy_q;
endmodule

// File: tb/tb_mem_responder.sv
// Drives two responders (WAIT_STATES=1 and 0) with identical requests and scoreboards both against a memory model.
module tb_mem_responder;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_responder_if if0 ();
  mem_responder_if if1 ();
  logic [1:0] led0, led1;
  logic       bad0, bad1;

  mem_responder #(.DEPTH_LOG2(10), .WAIT_STATES(1), .LED_ADDR(26'h3FFFFFF)) u0 (
    .clk(clk), .reset(reset), .mem(if0.slave), .led_reg(led0), .bad_access(bad0));
  mem_responder #(.DEPTH_LOG2(10), .WAIT_STATES(0), .LED_ADDR(26'h3FFFFFF)) u1 (
    .clk(clk), .reset(reset), .mem(if1.slave), .led_reg(led1), .bad_access(bad1));

`ifdef MEM_RESPONDER_LED_MMIO_EN
  localparam bit LED_EN = 1'b1;
`else
  localparam bit LED_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] dr;
    logic        bad;
    logic [1:0]  led;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int total = 0;
  int nbad = 0;
  int issued = 0;
  int done0 = 0, done1 = 0;
  int run0 = 0, run1 = 0;
  bit prev0 = 0, prev1 = 0;

  // Reference model: a word-addressed memory plus the visible responder registers.
  logic [31:0] m_ram [1024];
  int          wr_list[$];
  logic [31:0] m_dr = 32'd0;
  logic        m_bad = 1'b0;
  logic [1:0]  m_led = 2'b00;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic fail_now(string name);
    total++;
    nbad++;
    $display("FAIL %s: got timeout want completion", name);
  endtask

  function automatic exp_t model(bit rd, bit wr, logic [25:0] a, logic [31:0] d);
    exp_t e;
    bit is_led, is_ram;
    is_led = LED_EN && (a == 26'h3FFFFFF);
    is_ram = (a != 26'h3FFFFFF) && (a < 26'd1024);
    if (rd && wr) m_bad = 1'b1;
    if (wr) begin
      if (is_led) m_led = d[1:0];
      else if (is_ram) begin
        m_ram[a[9:0]] = d;
        wr_list.push_back(int'(a));
      end else m_bad = 1'b1;
    end else if (rd) begin
      if (is_led)      m_dr = {30'd0, m_led};
      else if (is_ram) m_dr = m_ram[a[9:0]];
      else begin
        m_dr  = 32'hDEADBEEF;
        m_bad = 1'b1;
      end
    end
    e.dr = m_dr;
    e.bad = m_bad;
    e.led = m_led;
    return e;
  endfunction

  task automatic set_req(bit rd, bit wr, logic [25:0] a, logic [31:0] d);
    if0.memory_read_req = rd;  if0.memory_write_req = wr;
    if0.memory_addr = a;       if0.memory_data_write = d;
    if1.memory_read_req = rd;  if1.memory_write_req = wr;
    if1.memory_addr = a;       if1.memory_data_write = d;
  endtask

  // One-cycle request pulse; address/data are scrambled afterwards to prove capture-at-accept.
  task automatic raw_req(bit rd, bit wr, logic [25:0] a, logic [31:0] d);
    set_req(rd, wr, a, d);
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 26'($urandom), $urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((if0.memory_busy || if1.memory_busy) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) fail_now("idle_timeout");
  endtask

  task automatic issue(bit rd, bit wr, logic [25:0] a, logic [31:0] d);
    exp_t e;
    wait_idle();
    e = model(rd, wr, a, d);
    q0.push_back(e);
    q1.push_back(e);
    issued++;
    raw_req(rd, wr, a, d);
  endtask

  task automatic check_done(string tag, int run, int ws, exp_t e,
                            logic [31:0] dr, logic b, logic [1:0] led);
    chk({tag, "_busy_len"}, run, ws + 2);
    chk({tag, "_data_read"}, dr, e.dr);
    chk({tag, "_bad_access"}, {31'd0, b}, {31'd0, e.bad});
    chk({tag, "_led_reg"}, {30'd0, led}, {30'd0, e.led});
  endtask

  always @(negedge clk) begin
    if (reset) begin
      prev0 = 0; run0 = 0;
    end else begin
      if (if0.memory_busy) run0++;
      else if (prev0) begin
        if (q0.size() == 0) chk("ws1_spurious_completion", 1, 0);
        else begin
          check_done("ws1", run0, 1, q0.pop_front(), if0.memory_data_read, bad0, led0);
          done0++;
        end
        run0 = 0;
      end
      prev0 = if0.memory_busy;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      prev1 = 0; run1 = 0;
    end else begin
      if (if1.memory_busy) run1++;
      else if (prev1) begin
        if (q1.size() == 0) chk("ws0_spurious_completion", 1, 0);
        else begin
          check_done("ws0", run1, 0, q1.pop_front(), if1.memory_data_read, bad1, led1);
          done1++;
        end
        run1 = 0;
      end
      prev1 = if1.memory_busy;
    end
  end

  task automatic random_ops(int n, bit allow_err);
    for (int i = 0; i < n; i++) begin
      int r;
      logic [25:0] a;
      logic [31:0] d;
      r = $urandom_range(0, 99);
      d = $urandom;
      if (r < 40 || wr_list.size() == 0) begin
        a = 26'($urandom_range(0, 1023));
        issue(1'b0, 1'b1, a, d);
      end else if (r < 80 || !allow_err) begin
        a = 26'(wr_list[$urandom_range(0, wr_list.size() - 1)]);
        issue(1'b1, 1'b0, a, 32'd0);
      end else if (r < 88) begin
        a = 26'(1024 + $urandom_range(0, 60000));
        issue(r[0], !r[0], a, d);
      end else if (r < 94) begin
        issue(r[0], !r[0], 26'h3FFFFFF, d);
      end else begin
        a = 26'($urandom_range(0, 1023));
        issue(1'b1, 1'b1, a, d);
      end
    end
  endtask

  initial begin
    set_req(1'b0, 1'b0, 26'd0, 32'd0);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy_ws1", {31'd0, if0.memory_busy}, 0);
    chk("rst_busy_ws0", {31'd0, if1.memory_busy}, 0);
    chk("rst_data_ws1", if0.memory_data_read, 32'h0);
    chk("rst_data_ws0", if1.memory_data_read, 32'h0);
    chk("rst_led_ws1", {30'd0, led0}, 0);
    chk("rst_bad_ws1", {31'd0, bad0}, 0);
    chk("rst_bad_ws0", {31'd0, bad1}, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    issue(1'b0, 1'b1, 26'd5, 32'hCAFEF00D);
    issue(1'b1, 1'b0, 26'd5, 32'd0);

    issue(1'b0, 1'b1, 26'd0, 32'h11111111);
    issue(1'b0, 1'b1, 26'd1, 32'h22222222);
    issue(1'b0, 1'b1, 26'd9, 32'h00000099);
    issue(1'b1, 1'b0, 26'd0, 32'd0);
    raw_req(1'b0, 1'b1, 26'd9, 32'h00001234);
    issue(1'b1, 1'b0, 26'd1, 32'd0);
    issue(1'b1, 1'b0, 26'd9, 32'd0);

    issue(1'b0, 1'b1, 26'd1023, 32'h0BADF00D);
    issue(1'b1, 1'b0, 26'd1023, 32'd0);

    random_ops(40, 1'b0);

    issue(1'b0, 1'b1, 26'h3FFFFFF, 32'h3);
    issue(1'b1, 1'b0, 26'h3FFFFFF, 32'd0);
    issue(1'b1, 1'b0, 26'h0000400, 32'd0);
    issue(1'b1, 1'b1, 26'd2, 32'h1);
    issue(1'b1, 1'b0, 26'd2, 32'd0);

    issue(1'b0, 1'b1, 26'd7, 32'hAA);
    wait_idle();
    @(negedge clk); #1;
    raw_req(1'b0, 1'b1, 26'd7, 32'h55);
    reset = 1'b1;
    #1;
    chk("midrst_busy_ws1", {31'd0, if0.memory_busy}, 0);
    chk("midrst_busy_ws0", {31'd0, if1.memory_busy}, 0);
    m_dr = 32'd0;
    m_bad = 1'b0;
    m_led = 2'b00;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_bad_ws1", {31'd0, bad0}, 0);
    chk("midrst_data_ws0", if1.memory_data_read, 32'h0);
    @(posedge clk); #1;
    issue(1'b1, 1'b0, 26'd7, 32'd0);

    random_ops(40, 1'b1);

    wait_idle();
    @(negedge clk); #1;
    chk("ws1_pending", q0.size(), 0);
    chk("ws0_pending", q1.size(), 0);
    chk("ws1_completions", done0, issued);
    chk("ws0_completions", done1, issued);

    $display("test done: total=%0d bad=%0d", total, nbad);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
# mem_responder

Responder end of the processor memory interface: accepts read and write requests from the control unit and serves them from an on-chip block RAM. It also serves one optional memory-mapped LED register. It sits where the hal normally answers `memory_read_req`/`memory_write_req`, and is used for bring-up and simulation without the DDR2 path. Its wait-state count is configurable, so control-unit stall handling can be exercised.

## Interface
Parameters:
- `DEPTH_LOG2`, default 10: RAM holds 2**DEPTH_LOG2 32-bit words.
- `WAIT_STATES`, default 1: extra busy cycles per access (0..15).
- `LED_ADDR`, default 26'h3FFFFFF: word address of the LED register.

Ports:
- `clk` input, 1 bit: single clock; all logic is on its rising edge.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `memory_read_req` input, 1 bit: read request pulse.
- `memory_write_req` input, 1 bit: write request pulse.
- `memory_addr` input, 26 bits: word address, sampled at accept.
- `memory_data_write` input, 32 bits: write data, sampled at accept.
- `memory_data_read` output, 32 bits: read data, registered and held until the next read completes.
- `memory_busy` output, 1 bit: registered; high while an access is in flight.
- `led_reg` output, 2 bits: LED register contents.
- `bad_access` output, 1 bit: sticky error flag; cleared only by reset.

## Operation
- FSM states: IDLE, WAIT, ACCESS.
- IDLE:
  - If `memory_read_req` or `memory_write_req` is high at a rising edge, the request is accepted.
  - On accept: latch addr, wdata and op; load the wait counter with WAIT_STATES; set `memory_busy` to 1; go to WAIT.
- WAIT:
  - Counter is 0: go to ACCESS.
  - Otherwise: decrement the counter.
- ACCESS: perform the operation at the edge leaving the state, then `memory_busy` goes to 0 and the FSM returns to IDLE.
  - RAM write: `ram[addr[DEPTH_LOG2-1:0]] <= wdata`.
  - RAM read: `memory_data_read <= ram[addr]`.
- Address decode, checked in order:
  1. addr == LED_ADDR (when the macro is enabled): write sets `led_reg <= wdata[1:0]`; read returns {30'b0, led_reg}.
  2. addr < 2**DEPTH_LOG2: RAM.
  3. Otherwise, unmapped: write is dropped; read returns 32'hDEADBEEF; `bad_access` is set.
- Read and write high on the same accept edge: the write is performed, the read is dropped, and `bad_access` is set.
- Requests arriving while not in IDLE are ignored. No queueing, no flag.
- Writes do not change `memory_data_read`.

## Timing
- Reset values:
  - `memory_busy` = 0
  - `memory_data_read` = 32'h0
  - `led_reg` = 2'b00
  - `bad_access` = 0
  - FSM = IDLE
  - RAM contents are not initialised or cleared.
- For a request accepted at edge N:
  - `memory_busy` is high from N to N+WAIT_STATES+2, i.e. for WAIT_STATES+2 cycles.
  - `memory_busy` falls at edge N+WAIT_STATES+2, on the same edge that `memory_data_read` is updated.
- The requester must not test `memory_busy` in the cycle of its request pulse. It treats the falling edge of `memory_busy` as completion.
- Back-to-back: a new request may be accepted on the first edge after `memory_busy` falls. Throughput is one access per WAIT_STATES+3 cycles.
- Reset mid-operation:
  - The FSM returns to IDLE immediately and `memory_busy` drops.
  - An in-flight write that has not reached the ACCESS exit edge is discarded.
- Address and write data are captured only at accept. Changes to the inputs afterwards have no effect.

## Configuration
- `MEM_RESPONDER_LED_MMIO_EN`:
  - Defined: the LED register exists at LED_ADDR.
  - Undefined: `led_reg` is tied to 2'b00, and LED_ADDR decodes as unmapped (read returns 32'hDEADBEEF; `bad_access` is set).

## Test plan
- Write then read (WAIT_STATES=1):
  - Stimulus: write 32'hCAFEF00D to addr 5, wait for `memory_busy` to fall, then read addr 5.
  - Required: `memory_busy` is high for exactly 3 cycles per access; `memory_data_read` = 32'hCAFEF00D on the edge `memory_busy` falls.
- Zero wait states and back-to-back:
  - Stimulus: WAIT_STATES=0; reads of addr 0 and addr 1 issued on consecutive allowed edges.
  - Required: `memory_busy` is high for 2 cycles each; no request is lost; a request pulsed while busy is ignored.
- LED MMIO with the macro defined:
  - Stimulus: write 32'h3 to 26'h3FFFFFF, then read it back.
  - Required: `led_reg` = 2'b11; readback = 32'h00000003.
  - Repeat without the macro. Required: `led_reg` = 2'b00; read returns 32'hDEADBEEF; `bad_access` = 1.
- Unmapped access and collision:
  - Stimulus: read addr 26'h0000400 (DEPTH_LOG2=10).
  - Required: read returns 32'hDEADBEEF and `bad_access` = 1.
  - Stimulus: read and write high on the same edge to addr 2, wdata 32'h1.
  - Required: RAM[2] = 1; `memory_data_read` unchanged; `bad_access` = 1.
- Reset mid-write:
  - Stimulus: write 32'h55 to addr 7 (old value 32'hAA); assert `reset` while in WAIT.
  - Required: `memory_busy` = 0 immediately; a later read of addr 7 returns 32'hAA.
